// File: rtl/delay_fx.sv
// ---------------------------------------------------------------------------
// delay_fx : feedback delay/echo stage, one sample per 5 clocks, RAM delay line
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module delay_fx #(
    parameter int BITS   = 8,
    parameter int DW     = 16,
    parameter int AW     = 12,
    parameter int DSHIFT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [DW-1:0]  in_sample,
    input  logic [BITS-1:0]       blend,
    input  logic [BITS-1:0]       delay,
    input  logic [BITS-1:0]       feedbk,
    output logic                  out_valid,
    output logic signed [DW-1:0]  out_sample
);

    localparam int PW = DW + BITS + 2;
    localparam logic [BITS:0]         C_WONE = {1'b1, {BITS{1'b0}}};
    localparam logic signed [PW-1:0]  C_SMAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0]  C_SMIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WT   = 3'd2,
        ST_MIX  = 3'd3,
        ST_WR   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [DW-1:0]   out_sample_q, out_sample_d;
    logic signed [DW-1:0]   dry_q, dry_d;
    logic [BITS-1:0]        blend_q, blend_d;
    logic [BITS-1:0]        dly_q, dly_d;
    logic [BITS-1:0]        fb_q, fb_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          fill_q, fill_d;
    logic signed [DW-1:0]   wdata_q, wdata_d;

    logic signed [DW-1:0]   mem [0:(1<<AW)-1];
    logic signed [DW-1:0]   rdata_q;

    logic [BITS:0]          w_blend, w_fb;
    logic [AW-1:0]          d_len, rd_addr, ram_addr;
    logic signed [DW-1:0]   wet;
    logic signed [PW-1:0]   dry_x, wet_x, mix_full, fb_sum;
    logic signed [DW-1:0]   mix_res, wsat;

    always_comb begin
        // weight 0..256 so that a full-scale byte gives an exact pass-through
        w_blend  = {1'b0, blend_q} + {{BITS{1'b0}}, blend_q[BITS-1]};
        w_fb     = {1'b0, fb_q} + {{BITS{1'b0}}, fb_q[BITS-1]};
        d_len    = (dly_q == '0) ? AW'(1) : (AW'(dly_q) << DSHIFT);
        rd_addr  = wr_ptr_q - d_len;
        wet      = (d_len > fill_q) ? '0 : rdata_q;
        dry_x    = {{(PW-DW){dry_q[DW-1]}}, dry_q};
        wet_x    = {{(PW-DW){wet[DW-1]}}, wet};
        mix_full = dry_x * $signed({{(PW-BITS-1){1'b0}}, C_WONE - w_blend})
                 + wet_x * $signed({{(PW-BITS-1){1'b0}}, w_blend});
        mix_res  = DW'(mix_full >>> BITS);
        fb_sum   = dry_x + ((wet_x * $signed({{(PW-BITS-1){1'b0}}, w_fb})) >>> BITS);
        if (fb_sum > C_SMAX) begin
            wsat = C_SMAX[DW-1:0];
        end else if (fb_sum < C_SMIN) begin
            wsat = C_SMIN[DW-1:0];
        end else begin
            wsat = fb_sum[DW-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        out_valid_d  = 1'b0;
        out_sample_d = out_sample_q;
        dry_d        = dry_q;
        blend_d      = blend_q;
        dly_d        = dly_q;
        fb_d         = fb_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        wdata_d      = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dry_d   = in_sample;
                    blend_d = blend;
                    dly_d   = delay;
                    fb_d    = feedbk;
                    state_d = ST_RD;
                end
            end
            ST_RD:  state_d = ST_WT;
            ST_WT:  state_d = ST_MIX;
            ST_MIX: begin
                out_sample_d = mix_res;
                wdata_d      = wsat;
                out_valid_d  = 1'b1;
                state_d      = ST_WR;
            end
            ST_WR: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                fill_d   = (fill_q == '1) ? fill_q : fill_q + AW'(1);
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            dry_q        <= '0;
            blend_q      <= '0;
            dly_q        <= '0;
            fb_q         <= '0;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
            dry_q        <= dry_d;
            blend_q      <= blend_d;
            dly_q        <= dly_d;
            fb_q         <= fb_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            wdata_q      <= wdata_d;
        end
    end

    // Single-port line: read in RD, write in WR; an async reset leaves state_q
    // in IDLE, so an abandoned sample never reaches the write.
    assign ram_addr = (state_q == ST_WR) ? wr_ptr_q : rd_addr;

    always_ff @(posedge clk) begin
        if (state_q == ST_WR) begin
            mem[ram_addr] <= wdata_q;
        end
        if (state_q == ST_RD) begin
            rdata_q <= mem[ram_addr];
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;

endmodule

`default_nettype wire

// File: tb/tb_delay_fx.sv
// ---------------------------------------------------------------------------
// tb_delay_fx : randomized and directed bench for delay_fx against a sample model
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_delay_fx;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_sample = '0;
    logic [7:0]         blend = '0;
    logic [7:0]         delay = '0;
    logic [7:0]         feedbk = '0;
    logic               out_valid;
    logic signed [15:0] out_sample;

    always #5 clk = ~clk;

    delay_fx #(.BITS(8), .DW(16), .AW(12), .DSHIFT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .blend      (blend),
        .delay      (delay),
        .feedbk     (feedbk),
        .out_valid  (out_valid),
        .out_sample (out_sample)
    );

    typedef struct {
        int exp;
        bit lit_en;
        int lit;
        int acc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   m_mem [4096];
    int   m_ptr = 0;
    int   m_fill = 0;
    bit   acc_valid = 1'b0;
    int   last_acc = 0;
    int   last_out = 0;
    int   n_out = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sample-level model: delay line as a circular array, fill-count guard.
    function automatic int model_step(input int s, input int b, input int d, input int f);
        int dl, wb, wf, wet, o, wv;
        dl  = (d == 0) ? 1 : d * 16;
        wb  = b + ((b >= 128) ? 1 : 0);
        wf  = f + ((f >= 128) ? 1 : 0);
        wet = (dl > m_fill) ? 0 : m_mem[(m_ptr - dl) & 4095];
        o   = (s * (256 - wb) + wet * wb) >>> 8;
        wv  = s + ((wet * wf) >>> 8);
        if (wv > 32767)  wv = 32767;
        if (wv < -32768) wv = -32768;
        m_mem[m_ptr] = wv;
        m_ptr  = (m_ptr + 1) % 4096;
        m_fill = (m_fill < 4095) ? m_fill + 1 : 4095;
        return o;
    endfunction

    // Called at a negedge; returns at the negedge just after the acceptance edge.
    task automatic send(input int s, input int b, input int d, input int f,
                        input bit le = 1'b0, input int lv = 0);
        int   g;
        exp_t e;
        g = 0;
        in_sample = 16'(s);
        blend     = 8'(b);
        delay     = 8'(d);
        feedbk    = 8'(f);
        in_valid  = 1'b1;
        while (!in_ready) begin
            @(negedge clk);
            g++;
            if (g > 20) begin
                chk("ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        acc_valid = 1'b1;
        last_acc  = cyc;
        e.exp     = model_step(s, b, d, f);
        e.lit_en  = le;
        e.lit     = lv;
        e.acc     = cyc;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        in_sample = 16'($urandom);
        blend     = 8'($urandom);
        delay     = 8'($urandom);
        feedbk    = 8'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int g;
        g = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        q.delete();
        acc_valid = 1'b0;
        m_ptr     = 0;
        m_fill    = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Compare process: handshake timing, output values and hold behaviour.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_rdy;
        if (!reset_n) begin
            last_out = 0;
        end else begin
            exp_rdy = !(acc_valid && (cyc - last_acc) >= 1 && (cyc - last_acc) <= 4);
            chk("in_ready", int'(in_ready), int'(exp_rdy));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_sample_model", int'(out_sample), e.exp);
                    chk("latency", cyc - e.acc, 4);
                    if (e.lit_en) chk("out_sample_literal", int'(out_sample), e.lit);
                end
                last_out = int'(out_sample);
                n_out++;
            end else begin
                chk("out_sample_hold", int'(out_sample), last_out);
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int pulses;
        int b, d;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sample", int'(out_sample), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Dry pass-through
        send(1000, 0, 0, 0, 1'b1, 1000);
        drain();

        // Reset during MIX abandons the sample
        in_sample = 16'sd777;
        blend     = 8'd255;
        delay     = 8'd0;
        feedbk    = 8'd0;
        in_valid  = 1'b1;
        while (!in_ready) @(negedge clk);
        acc_valid = 1'b1;
        last_acc  = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pulses    = n_out;
        reset_n   = 1'b0;
        acc_valid = 1'b0;
        m_ptr     = 0;
        m_fill    = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_out_valid", n_out, pulses);
        chk("abort_in_ready", int'(in_ready), 1);
        send(1234, 255, 0, 0, 1'b1, 0);
        drain();

        // Impulse through D=16, no feedback
        do_reset();
        for (int i = 0; i <= 40; i++)
            send((i == 0) ? 10000 : 0, 255, 1, 0, 1'b1, (i == 16) ? 10000 : 0);
        drain();

        // Impulse with feedback 128
        do_reset();
        for (int i = 0; i <= 48; i++)
            send((i == 0) ? 16384 : 0, 255, 1, 128, 1'b1,
                 (i == 16) ? 16384 : (i == 32) ? 8256 : (i == 48) ? 4160 : 0);

        // Minimum delay and write saturation both ways
        send(500, 255, 0, 0);
        send(0, 255, 0, 0, 1'b1, 500);
        send(30000, 0, 0, 0, 1'b1, 30000);
        send(30000, 0, 0, 255, 1'b1, 30000);
        send(0, 255, 0, 0, 1'b1, 32767);
        send(-30000, 0, 0, 0, 1'b1, -30000);
        send(-30000, 0, 0, 255, 1'b1, -30000);
        send(0, 255, 0, 0, 1'b1, -32768);
        drain();

        // Randomized traffic, mostly back-to-back
        for (int i = 0; i < 1500; i++) begin
            if ($urandom % 8 == 0) idle(int'($urandom % 4));
            case ($urandom % 4)
                0:       b = 0;
                1:       b = 255;
                2:       b = 128;
                default: b = int'($urandom % 256);
            endcase
            d = ($urandom % 4 == 0) ? int'($urandom % 256) : int'($urandom % 3);
            send(int'($urandom_range(65535)) - 32768, b, d, int'($urandom % 256));
        end
        drain();

        // Fill the whole line with full scale, then reset and check the guard
        for (int i = 0; i < 4096; i++)
            send(32767, 0, 0, 0, 1'b1, 32767);
        drain();
        do_reset();
        for (int i = 0; i < 4100; i++)
            send(0, 255, 255, int'($urandom % 256), 1'b1, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
